dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the pipelined CPU's memory stage and a slower handshaked main memory. Consumes the M-stage address, store data, and read/write strobes. Returns load data combinationally on a hit; on a miss or any store it asserts a stall that freezes the CPU pipeline until memory completes.

---
 rtl/dcache_pkg.sv | 11 +
 rtl/dcache_array.sv | 34 +++
 rtl/dcache.sv | 66 ++++++
 tb/tb_dcache.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding, default geometry and address split helpers
package dcache_pkg;
  localparam int DEF_INDEX_BITS = 6;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  function automatic logic [31:0] line_index(input logic [31:0] a, input int ib);
    return (a >> 2) & ((32'd1 << ib) - 32'd1);
  endfunction
  function automatic logic [31:0] line_tag(input logic [31:0] a, input int ib);
    return a >> (ib + 2);
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data line storage, combinational read, synchronous write
module dcache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] ridx,
  output logic                  rvalid,
  output logic [TAG_BITS-1:0]   rtag,
  output logic [31:0]           rdata,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] widx,
  input  logic [TAG_BITS-1:0]   wtag,
  input  logic [31:0]           wdata
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0] data [LINES];
  assign rvalid = valid[ridx];
  assign rtag = tags[ridx];
  assign rdata = data[ridx];
  // valid bits clear on reset; a write always leaves its line valid
  always_ff @(posedge clk)
    if (reset) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  // tag and data storage need no reset since valid gates their use
  always_ff @(posedge clk)
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-through no-write-allocate data cache with stall FSM
module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  localparam int TAG_BITS = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  state_t state;
  logic [31:0] lat_addr, lat_wdata, rd_addr, rd_data;
  logic lat_we, rd_valid, hit, done, idle;
  logic [TAG_BITS-1:0] rd_tag;
  // the read port looks at the CPU address when idle and at the pending access while waiting,
  // so a store completion can test its own line
  assign idle = state == IDLE;
  assign rd_addr = idle ? cpu_addr : lat_addr;
  assign hit = rd_valid && rd_tag == TAG_BITS'(line_tag(rd_addr, INDEX_BITS));
  assign done = !idle && mem_ready;
  assign cpu_stall = idle ? (cpu_write || (cpu_read && !hit)) : !mem_ready;
  assign cpu_rdata = (state == RD_WAIT && mem_ready) ? mem_rdata : (idle && cpu_read && hit) ? rd_data : '0;
  assign mem_req = !idle;
  assign mem_we = lat_we;
  assign mem_addr = lat_addr;
  assign mem_wdata = lat_wdata;
  dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk   (clk),
    .reset (reset),
    .ridx  (INDEX_BITS'(line_index(rd_addr, INDEX_BITS))),
    .rvalid(rd_valid),
    .rtag  (rd_tag),
    .rdata (rd_data),
    .we    (done && (state == RD_WAIT || hit)),
    .widx  (INDEX_BITS'(line_index(lat_addr, INDEX_BITS))),
    .wtag  (TAG_BITS'(line_tag(lat_addr, INDEX_BITS))),
    .wdata (state == RD_WAIT ? mem_rdata : lat_wdata)
  );
  // request FSM: stores always go to memory, loads only on a miss; the latch holds the request stable
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_we <= 1'b0;
    end else if (idle) begin
      if (cpu_write || (cpu_read && !hit)) begin
        state <= cpu_write ? WR_WAIT : RD_WAIT;
        lat_addr <= {cpu_addr[31:2], 2'b00};
        lat_wdata <= cpu_wdata;
        lat_we <= cpu_write;
      end
    end else if (mem_ready) state <= IDLE;
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: randomized and directed checks of dcache against a behavioural cache/memory model
module tb_dcache;
  localparam int IB = 6;
  localparam int LINES = 1 << IB;
  logic clk = 0, reset = 1;
  logic cpu_read = 0, cpu_write = 0, mem_ready = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, mem_rdata = 0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic cpu_stall, mem_req, mem_we;
  int n_cmp = 0, n_bad = 0;
  bit m_valid [LINES];
  int unsigned m_tag [LINES];
  logic [31:0] m_data [LINES];
  logic [31:0] mem [int unsigned];

  dcache #(.INDEX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] wa);
    logic [31:0] x;
    x = wa * 32'h9E3779B1 + 32'h1234567;
    return mem.exists(wa) ? mem[wa] : x;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
  endtask

  // one CPU access presented at a negedge; the bench plays memory with lat extra wait cycles
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd, input int lat);
    int idx;
    int unsigned tg;
    logic [31:0] wa, exp_rd;
    bit mhit, to_mem;
    idx = int'((a >> 2) % LINES);
    tg = a >> (IB + 2);
    wa = a & 32'hFFFF_FFFC;
    mhit = m_valid[idx] && m_tag[idx] == tg;
    to_mem = wr || (rd && !mhit);
    exp_rd = mhit ? m_data[idx] : mem_val(wa);
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd; mem_ready = 0;
    #1;
    check("detect_stall", cpu_stall, to_mem);
    check("detect_req", mem_req, 0);
    if (rd && !wr && !to_mem) check("hit_rdata", cpu_rdata, exp_rd);
    @(negedge clk);
    if (to_mem) begin
      for (int k = 0; k < lat; k++) begin
        #1;
        check("wait_stall", cpu_stall, 1);
        check("wait_req", mem_req, 1);
        check("wait_we", mem_we, wr);
        check("wait_addr", mem_addr, wa);
        if (wr) check("wait_wdata", mem_wdata, wd);
        @(negedge clk);
      end
      mem_ready = 1;
      mem_rdata = wr ? $urandom : mem_val(wa);
      #1;
      check("ready_stall", cpu_stall, 0);
      check("ready_req", mem_req, 1);
      check("ready_addr", mem_addr, wa);
      if (!wr) check("fill_rdata", cpu_rdata, exp_rd);
      @(negedge clk);
      mem_ready = 0;
      if (wr) begin
        mem[wa] = wd;
        if (mhit) m_data[idx] = wd;
      end else begin
        m_valid[idx] = 1; m_tag[idx] = tg; m_data[idx] = exp_rd;
      end
    end
    cpu_read = 0; cpu_write = 0;
  endtask

  initial begin
    logic [31:0] a;
    clear_model();
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_stall", cpu_stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", cpu_rdata, 0);
    reset = 0;
    @(negedge clk);
    mem[32'h100] = 32'hDEADBEEF;
    access(1, 0, 32'h100, 0, 2);
    access(1, 0, 32'h100, 0, 0);
    access(0, 1, 32'h100, 32'hCAFEF00D, 1);
    access(1, 0, 32'h100, 0, 3);
    check("store_hit_data", m_data[(32'h100 >> 2) % LINES], 32'hCAFEF00D);
    access(0, 1, 32'h300, 32'h1111_2222, 0);
    access(1, 0, 32'h300, 0, 1);
    access(1, 0, 32'h100, 0, 0);
    access(1, 0, 32'h100 + (4 << IB), 0, 2);
    access(1, 0, 32'h100, 0, 1);
    access(1, 1, 32'h104, 32'h5555AAAA, 0);
    access(0, 0, 32'h100, 0, 0);
    // reset while a refill is pending: request withdrawn, line stays invalid
    cpu_read = 1; cpu_addr = 32'h4C0; mem_ready = 0;
    @(negedge clk);
    #1;
    check("midrst_req_before", mem_req, 1);
    reset = 1; cpu_read = 0;
    @(negedge clk);
    #1;
    check("midrst_req_after", mem_req, 0);
    reset = 0;
    clear_model();
    @(negedge clk);
    access(1, 0, 32'h4C0, 0, 1);
    // memory completion pulse with nothing pending must be ignored
    mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
    #1;
    check("idle_ready_stall", cpu_stall, 0);
    check("idle_ready_req", mem_req, 0);
    @(negedge clk);
    mem_ready = 0;
    access(1, 0, 32'h4C0, 0, 0);
    access(1, 0, 32'h8C0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) << (IB + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0, 1, 2: access(1, 0, a, 0, $urandom_range(0, 3));
        3: access(0, 1, a, $urandom, $urandom_range(0, 3));
        4: access(1, 1, a, $urandom, $urandom_range(0, 3));
        default: access(0, 0, a, 0, 0);
      endcase
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
